// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the 17-bit ALU and the division controller that
// feeds it:
//   - XW / YW   : ALU X and Y operand widths
//   - FS_*      : func_sel op-code encoding understood by the ALU
//   - div_state_e : state encoding of the restoring-division controller
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int XW = 17;
    localparam int YW = 8;

    localparam logic [3:0] FS_PASS = 4'd0;
    localparam logic [3:0] FS_ADD  = 4'd1;
    localparam logic [3:0] FS_SUB  = 4'd2;
    localparam logic [3:0] FS_AND  = 4'd3;
    localparam logic [3:0] FS_OR   = 4'd4;
    localparam logic [3:0] FS_XOR  = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_UPDATE,
        ST_FIN
    } div_state_e;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl_if
// Operand/result bus between the division controller and the ALU.
//   alu_x        : X operand (XW bits)          controller -> ALU
//   alu_y        : Y operand (YW bits)          controller -> ALU
//   alu_func_sel : op code (FS_* from alu_pkg)  controller -> ALU
//   alu_z        : result (XW bits)             ALU -> controller
//   alu_bo       : borrow, 1 when X < Y         ALU -> controller
//   alu_eqz      : result-is-zero flag          ALU -> controller
// Modports: master = controller side, slave = ALU side.
// ---------------------------------------------------------------------------
interface div_seq_ctrl_if;
    import alu_pkg::*;

    logic [XW-1:0] alu_x;
    logic [YW-1:0] alu_y;
    logic [3:0]    alu_func_sel;
    logic [XW-1:0] alu_z;
    logic          alu_bo;
    logic          alu_eqz;

    modport master (
        output alu_x, alu_y, alu_func_sel,
        input  alu_z, alu_bo, alu_eqz
    );

    modport slave (
        input  alu_x, alu_y, alu_func_sel,
        output alu_z, alu_bo, alu_eqz
    );

endinterface

// File: rtl/div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl
// Sequential restoring divider controller: DW-bit dividend / 8-bit divisor,
// one quotient bit per iteration, using an external ALU for the trial
// subtraction R' - D.
//
// Ports:
//   clk          : rising-edge clock
//   rst          : synchronous reset, active low
//   start        : request pulse, only honoured in IDLE
//   dividend     : numerator, captured on start acceptance
//   divisor      : denominator, captured on start acceptance
//   busy         : high from start acceptance until done
//   done         : one-cycle completion pulse
//   div_by_zero  : valid with done, set when the divisor was 0
//   quotient     : result, held until the next completion
//   remainder    : result, held until the next completion
//   alu          : div_seq_ctrl_if.master, ALU operand/result bus
//
// Parameters:
//   ALU_LAT : cycles from operand drive to valid Z/Bo (1..4)
//   DW      : dividend/quotient width
//
// Build option:
//   DIVCTRL_ZERO_SKIP_EN : when defined, a zero dividend with a non-zero
//                          divisor finishes straight from LOAD without
//                          issuing any ALU operation.
//
// Timing: every output is registered. The work of ISSUE (form R', shift Q,
// drive the ALU) is done on the edge that enters ISSUE so that the ALU
// operands are already stable during the ISSUE cycle. Likewise the FIN
// results and done are registered on the edge that leaves FIN, giving a
// start-to-done latency of 2 + DW*(1+ALU_LAT) cycles.
// ---------------------------------------------------------------------------
module div_seq_ctrl
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [YW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero,
    output logic [DW-1:0] quotient,
    output logic [YW-1:0] remainder,
    div_seq_ctrl_if.master alu
);

`ifdef DIVCTRL_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    localparam int KW = $clog2(DW + 1);

    div_state_e    state_q;
    logic [YW-1:0] d_q;        // captured divisor
    logic [DW-1:0] q_q;        // dividend bits shifting out / quotient shifting in
    logic [YW-1:0] r_q;        // partial remainder
    logic [YW:0]   rp_q;       // shifted remainder R' kept for the restore path
    logic [KW-1:0] k_q;        // iterations left
    logic [1:0]    w_q;        // extra WAIT cycles left
    logic          dz_q;       // divide-by-zero seen for the current operation

    logic          busy_q;
    logic          done_q;
    logic          div_by_zero_q;
    logic [DW-1:0] quotient_q;
    logic [YW-1:0] remainder_q;
    logic [XW-1:0] alu_x_q;
    logic [YW-1:0] alu_y_q;
    logic [3:0]    alu_func_sel_q;

    // Result of the current iteration (meaningful in UPDATE) and the R' for
    // the next trial subtraction. Outside UPDATE, R/Q pass through so the
    // first R' can be formed from LOAD as well.
    logic [YW-1:0] r_d;
    logic [DW-1:0] q_d;
    logic [YW:0]   rp_d;

    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        r_d = r_q;
        q_d = q_q;
        if (state_q == ST_UPDATE) begin
            if (!alu.alu_bo) begin
                // No borrow: the difference is < D, so only the low byte matters.
                r_d = alu.alu_z[YW-1:0];
                q_d = {q_q[DW-1:1], 1'b1};
            end else begin
                r_d = rp_q[YW-1:0];
                q_d = {q_q[DW-1:1], 1'b0};
            end
        end
        rp_d = {r_d, q_d[DW-1]};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            d_q            <= '0;
            q_q            <= '0;
            r_q            <= '0;
            rp_q           <= '0;
            k_q            <= '0;
            w_q            <= '0;
            dz_q           <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            div_by_zero_q  <= 1'b0;
            quotient_q     <= '0;
            remainder_q    <= '0;
            alu_x_q        <= '0;
            alu_y_q        <= '0;
            alu_func_sel_q <= FS_PASS;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        d_q     <= divisor;
                        q_q     <= dividend;
                        r_q     <= '0;
                        k_q     <= KW'(DW);
                        dz_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (d_q == '0) begin
                        dz_q    <= 1'b1;
                        q_q     <= '1;
                        r_q     <= '0;
                        state_q <= ST_FIN;
                    end else if (ZERO_SKIP && (q_q == '0)) begin
                        r_q     <= '0;
                        state_q <= ST_FIN;
                    end else begin
                        r_q            <= r_d;
                        q_q            <= {q_d[DW-2:0], 1'b0};
                        rp_q           <= rp_d;
                        alu_x_q        <= {{(XW-YW-1){1'b0}}, rp_d};
                        alu_y_q        <= d_q;
                        alu_func_sel_q <= FS_SUB;
                        state_q        <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (ALU_LAT == 1) begin
                        state_q <= ST_UPDATE;
                    end else begin
                        w_q     <= 2'(ALU_LAT - 2);
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (w_q == '0) begin
                        state_q <= ST_UPDATE;
                    end else begin
                        w_q <= w_q - 2'd1;
                    end
                end

                ST_UPDATE: begin
                    k_q <= k_q - 1'b1;
                    if (k_q == KW'(1)) begin
                        r_q            <= r_d;
                        q_q            <= q_d;
                        alu_x_q        <= '0;
                        alu_y_q        <= '0;
                        alu_func_sel_q <= FS_PASS;
                        state_q        <= ST_FIN;
                    end else begin
                        r_q            <= r_d;
                        q_q            <= {q_d[DW-2:0], 1'b0};
                        rp_q           <= rp_d;
                        alu_x_q        <= {{(XW-YW-1){1'b0}}, rp_d};
                        alu_y_q        <= d_q;
                        alu_func_sel_q <= FS_SUB;
                        state_q        <= ST_ISSUE;
                    end
                end

                ST_FIN: begin
                    quotient_q    <= q_q;
                    remainder_q   <= r_q;
                    div_by_zero_q <= dz_q;
                    done_q        <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= ST_IDLE;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The upper result bits and the zero flag carry no information for this
    // algorithm; they are gathered here to mark them as intentionally unused.
    logic unused_alu;
    assign unused_alu = &{1'b0, alu.alu_z[XW-1:YW], alu.alu_eqz};

    assign busy             = busy_q;
    assign done             = done_q;
    assign div_by_zero      = div_by_zero_q;
    assign quotient         = quotient_q;
    assign remainder        = remainder_q;
    assign alu.alu_x        = alu_x_q;
    assign alu.alu_y        = alu_y_q;
    assign alu.alu_func_sel = alu_func_sel_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_seq_ctrl
// Drives two div_seq_ctrl instances (ALU_LAT=1 and ALU_LAT=3) from the same
// stimulus, each attached to a behavioural registered ALU with the matching
// latency. Expected results come from integer division and the documented
// latency formula. Honours DIVCTRL_ZERO_SKIP_EN for the zero-dividend case.
// ---------------------------------------------------------------------------
module tb_div_seq_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;

    logic        busy_w [2];
    logic        done_w [2];
    logic        dz_w   [2];
    logic [15:0] quo_w  [2];
    logic [7:0]  rem_w  [2];
    logic [16:0] ax_w   [2];
    logic [7:0]  ay_w   [2];
    logic [3:0]  fs_w   [2];

    int checks   = 0;
    int failures = 0;

    div_seq_ctrl_if if1 ();
    div_seq_ctrl_if if3 ();

    div_seq_ctrl #(.ALU_LAT(1), .DW(16)) dut1 (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy_w[0]), .done(done_w[0]), .div_by_zero(dz_w[0]),
        .quotient(quo_w[0]), .remainder(rem_w[0]), .alu(if1.master)
    );

    div_seq_ctrl #(.ALU_LAT(3), .DW(16)) dut3 (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy_w[1]), .done(done_w[1]), .div_by_zero(dz_w[1]),
        .quotient(quo_w[1]), .remainder(rem_w[1]), .alu(if3.master)
    );

    assign ax_w[0] = if1.alu_x;
    assign ay_w[0] = if1.alu_y;
    assign fs_w[0] = if1.alu_func_sel;
    assign ax_w[1] = if3.alu_x;
    assign ay_w[1] = if3.alu_y;
    assign fs_w[1] = if3.alu_func_sel;

    initial forever #5 clk = ~clk;

    // ---------------- behavioural ALU ----------------
    function automatic logic [16:0] alu_res(input logic [16:0] x, input logic [7:0] y,
                                            input logic [3:0] f);
        case (f)
            FS_ADD:  return x + {9'd0, y};
            FS_SUB:  return x - {9'd0, y};
            FS_AND:  return x & {9'd0, y};
            FS_OR:   return x | {9'd0, y};
            FS_XOR:  return x ^ {9'd0, y};
            default: return x;
        endcase
    endfunction

    function automatic logic alu_borrow(input logic [16:0] x, input logic [7:0] y,
                                        input logic [3:0] f);
        return (f == FS_SUB) && (x < {9'd0, y});
    endfunction

    logic [16:0] z1;
    logic        bo1;
    logic [16:0] z3 [3];
    logic        bo3 [3];

    always @(posedge clk) begin
        z1     <= alu_res(if1.alu_x, if1.alu_y, if1.alu_func_sel);
        bo1    <= alu_borrow(if1.alu_x, if1.alu_y, if1.alu_func_sel);
        z3[0]  <= alu_res(if3.alu_x, if3.alu_y, if3.alu_func_sel);
        bo3[0] <= alu_borrow(if3.alu_x, if3.alu_y, if3.alu_func_sel);
        z3[1]  <= z3[0];
        bo3[1] <= bo3[0];
        z3[2]  <= z3[1];
        bo3[2] <= bo3[1];
    end

    assign if1.alu_z   = z1;
    assign if1.alu_bo  = bo1;
    assign if1.alu_eqz = (z1 == '0);
    assign if3.alu_z   = z3[2];
    assign if3.alu_bo  = bo3[2];
    assign if3.alu_eqz = (z3[2] == '0);

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string nm);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s busy[%0d]", nm, d), 32'(busy_w[d]), 0);
            check($sformatf("%s done[%0d]", nm, d), 32'(done_w[d]), 0);
            check($sformatf("%s dz[%0d]", nm, d), 32'(dz_w[d]), 0);
            check($sformatf("%s quotient[%0d]", nm, d), 32'(quo_w[d]), 0);
            check($sformatf("%s remainder[%0d]", nm, d), 32'(rem_w[d]), 0);
            check($sformatf("%s alu_x[%0d]", nm, d), 32'(ax_w[d]), 0);
            check($sformatf("%s alu_y[%0d]", nm, d), 32'(ay_w[d]), 0);
            check($sformatf("%s func_sel[%0d]", nm, d), 32'(fs_w[d]), 32'(FS_PASS));
        end
    endtask

    // One division on both instances. extra_at > 0 pulses a second start
    // (with different operands) during cycle extra_at after acceptance.
    task automatic do_div(input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er, input logic edz,
                          input int extra_at, input string nm);
        int  exp_lat [2];
        int  exp_sub [2];
        int  lat     [2];
        int  ndone   [2];
        int  nsub    [2];
        int  busy_at_done [2];
        int  win;
        bit  short_path;

        short_path = (b == 8'd0);
`ifdef DIVCTRL_ZERO_SKIP_EN
        if (a == 16'd0) short_path = 1'b1;
`endif
        exp_lat[0] = short_path ? 2 : 2 + 16 * (1 + 1);
        exp_lat[1] = short_path ? 2 : 2 + 16 * (1 + 3);
        exp_sub[0] = short_path ? 0 : 16 * (1 + 1);
        exp_sub[1] = short_path ? 0 : 16 * (1 + 3);
        win = 2 + 16 * 4 + 6;
        for (int d = 0; d < 2; d++) begin
            lat[d] = -1; ndone[d] = 0; nsub[d] = 0; busy_at_done[d] = 0;
        end

        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("%s busy1 after accept", nm), 32'(busy_w[0]), 1);
        check($sformatf("%s busy3 after accept", nm), 32'(busy_w[1]), 1);

        for (int cyc = 1; cyc <= win; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (done_w[d]) begin
                    ndone[d]++;
                    if (lat[d] < 0) begin
                        lat[d] = cyc;
                        busy_at_done[d] = int'(busy_w[d]);
                    end
                end
                if (fs_w[d] == FS_SUB) nsub[d]++;
            end
            if (cyc == extra_at) begin
                start    = 1'b1;
                dividend = 16'd999;
                divisor  = 8'd2;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;

        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s latency[%0d]", nm, d), 32'(lat[d]), 32'(exp_lat[d]));
            check($sformatf("%s done pulses[%0d]", nm, d), 32'(ndone[d]), 1);
            check($sformatf("%s busy at done[%0d]", nm, d), 32'(busy_at_done[d]), 0);
            check($sformatf("%s sub cycles[%0d]", nm, d), 32'(nsub[d]), 32'(exp_sub[d]));
            check($sformatf("%s quotient[%0d]", nm, d), 32'(quo_w[d]), 32'(eq));
            check($sformatf("%s remainder[%0d]", nm, d), 32'(rem_w[d]), 32'(er));
            check($sformatf("%s div_by_zero[%0d]", nm, d), 32'(dz_w[d]), 32'(edz));
            check($sformatf("%s idle after[%0d]", nm, d), 32'(busy_w[d]), 0);
        end
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          extra_at;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int ndone_rst;

        vecs[0] = '{a: 16'd1000,  b: 8'd7,   q: 16'd142,   r: 8'd6,   dz: 1'b0, extra_at: 0};
        vecs[1] = '{a: 16'd65535, b: 8'd255, q: 16'd257,   r: 8'd0,   dz: 1'b0, extra_at: 33};
        vecs[2] = '{a: 16'd65535, b: 8'd1,   q: 16'd65535, r: 8'd0,   dz: 1'b0, extra_at: 0};
        vecs[3] = '{a: 16'd5,     b: 8'd9,   q: 16'd0,     r: 8'd5,   dz: 1'b0, extra_at: 0};
        vecs[4] = '{a: 16'd1234,  b: 8'd0,   q: 16'hFFFF,  r: 8'd0,   dz: 1'b1, extra_at: 0};
        vecs[5] = '{a: 16'd0,     b: 8'd5,   q: 16'd0,     r: 8'd0,   dz: 1'b0, extra_at: 0};
        vecs[6] = '{a: 16'd254,   b: 8'd255, q: 16'd0,     r: 8'd254, dz: 1'b0, extra_at: 0};
        vecs[7] = '{a: 16'd65535, b: 8'd128, q: 16'd511,   r: 8'd127, dz: 1'b0, extra_at: 0};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("reset");

        for (int i = 0; i < 8; i++) begin
            do_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz,
                   vecs[i].extra_at, $sformatf("vec%0d", i));
        end

        // Abort mid-run with a one-cycle reset at cycle 10 after acceptance.
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_idle_zero("abort");
        ndone_rst = 0;
        repeat (80) begin
            @(negedge clk);
            if (done_w[0] || done_w[1] || busy_w[0] || busy_w[1]) ndone_rst++;
        end
        check("abort no activity", 32'(ndone_rst), 0);

        // Restart after abort, with a stray start while busy.
        do_div(16'd100, 8'd3, 16'd33, 8'd1, 1'b0, 5, "restart");

        // Randomised operands against integer division.
        for (int i = 0; i < 14; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            a = 16'($urandom_range(0, 65535));
            b = 8'($urandom_range(0, 255));
            if (i == 0) b = 8'd0;
            if (b == 8'd0)
                do_div(a, b, 16'hFFFF, 8'd0, 1'b1, 0, $sformatf("rand%0d", i));
            else
                do_div(a, b, a / 16'(b), 8'(a % 16'(b)), 1'b0, 0, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequential restoring-division controller that sits directly upstream of the 17-bit ALU.
- Feeds the ALU its operands on X and Y and an op code on func_sel, then consumes Z and the borrow flag Bo to divide a 16-bit dividend by an 8-bit divisor, one quotient bit per iteration.
- Owns the partial-remainder and quotient registers and a start/done handshake toward the issuing sequencer.

Parameters:
- ALU_LAT, 1: cycles from operand drive until Z/Bo/eqz are valid (1 = registered ALU; range 1-4).
- DW, 16: dividend/quotient width; the ALU X width is DW+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low
- start  input  1  request pulse; sampled only in IDLE
- dividend  input  16  numerator, captured when start is accepted
- divisor  input  8  denominator, captured when start is accepted
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle completion pulse
- div_by_zero  output  1  valid with done; high if the captured divisor was 0
- quotient  output  16  result, held until the next accepted start
- remainder  output  8  result, held until the next accepted start
- alu_x  output  17  ALU X operand
- alu_y  output  8  ALU Y operand
- alu_func_sel  output  4  ALU op code
- alu_z  input  17  ALU result
- alu_bo  input  1  ALU borrow (1 = X<Y)
- alu_eqz  input  1  ALU zero flag; not used in the base build

Behaviour:
- Reset (rst==0 at a clock edge):
  - FSM goes to IDLE.
  - busy, done and div_by_zero are 0.
  - quotient and remainder are 0.
  - alu_x and alu_y are 0; alu_func_sel is FS_PASS (0).
  - Reset in any state aborts the operation. No done is produced.
- States: IDLE, LOAD, ISSUE, WAIT, UPDATE, FIN.
- IDLE:
  - start==1 captures D=divisor, Q=dividend, R=0, bit count k=DW, sets busy=1, goes to LOAD.
  - start while busy is ignored and does not queue.
- LOAD:
  - D==0 sets div_by_zero=1, quotient=16'hFFFF, remainder=0, goes to FIN. No ALU op is issued.
  - Otherwise goes to ISSUE.
- ISSUE (one cycle):
  - Forms R' = {R[7:0], Q[DW-1]} (9 bits).
  - Shifts Q left by 1.
  - Drives alu_x = zero-extended R', alu_y = D, alu_func_sel = FS_SUB (2).
  - Latches R' internally.
  - Then goes to WAIT.
- WAIT:
  - Holds alu_x, alu_y and alu_func_sel stable for ALU_LAT-1 cycles.
  - With ALU_LAT==1 it lasts 0 cycles, i.e. ISSUE goes straight to UPDATE.
- UPDATE: samples alu_z and alu_bo.
  - Bo==0: R = alu_z[7:0], Q[0] = 1.
  - Bo==1: R = R'[7:0] (restore), Q[0] = 0.
  - Decrements k. Goes to FIN if k==0, otherwise to ISSUE.
- FIN:
  - quotient = Q, remainder = R.
  - done = 1 for this cycle only; busy drops in the same cycle.
  - Next state is IDLE. A start asserted in FIN is ignored, and start is accepted from the following cycle.
- Latency from the start-accept edge to the done cycle is 2 + DW*(1+ALU_LAT), i.e. 34 cycles at the defaults.
- Width rule: R' ≤ 2*254+1 = 509 fits 9 bits. A no-borrow result is always < D, so alu_z[16:8] is ignored by design.
- Outside ISSUE, WAIT and UPDATE, the ALU outputs return to 0 / FS_PASS.

Optional Feature:
- Macro: DIVCTRL_ZERO_SKIP_EN.
- Defined: in LOAD, if D!=0 and the captured dividend==0, the block sets quotient=0, remainder=0, div_by_zero=0 and goes straight to FIN. Done arrives 2 cycles after acceptance and no ALU ops are issued.
- Undefined: a zero dividend runs all DW iterations and produces the same results with full latency.

Decomposition:
- Shared package alu_pkg holds:
  - the func_sel encoding constants (FS_PASS=0, FS_ADD=1, FS_SUB=2, ...), shared with the ALU;
  - the state enumeration type;
  - widths XW=17 and YW=8.
- No sub-module is needed. A small iteration/latency counter is kept inline.
- Bench: instantiates the existing ALU as the downstream model, or a behavioural equivalent with registered output (ALU_LAT=1).

Test Plan:
- dividend=1000, divisor=7, start pulse → done exactly 34 cycles later; quotient=142, remainder=6, div_by_zero=0; alu_func_sel==2 in 16 ISSUE cycles.
- dividend=65535, divisor=255 → quotient=257, remainder=0. Repeat with divisor=1 → quotient=65535, remainder=0.
- dividend=5, divisor=9 → quotient=0, remainder=5. Repeat with ALU_LAT=3 → done after 2+16*4=66 cycles, same results.
- divisor=0, dividend=1234 → done 2 cycles after acceptance; div_by_zero=1, quotient=16'hFFFF, remainder=0; no FS_SUB issued.
- Start 1000/7, pull rst low at cycle 10 for 1 cycle → all outputs 0, no done. Restart 100/3 → quotient=33, remainder=1. A second start pulsed while busy has no effect.
- With DIVCTRL_ZERO_SKIP_EN: dividend=0, divisor=5 → done 2 cycles after acceptance, quotient=0, remainder=0. Without the macro → done at 34 cycles, same values.
